fetch_unit: RTL and testbench

//  Instruction-fetch stage that sits directly downstream of pc_mux. Holds the

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: pc_mux link, instruction bus and decode handshake.
interface fetch_unit_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic [XLEN-1:0] pc_nxt;
    logic            redirect;
    logic [XLEN-1:0] pcplus4;
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok;
    logic [ILEN-1:0] iresp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_misalign;

    // Fetch unit side
    modport master (
        input  pc_nxt, redirect, iresp_data_ok, iresp_data, out_ready,
        output pcplus4, ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_misalign
    );

    // Environment side (pc_mux, memory, decode)
    modport slave (
        output pc_nxt, redirect, iresp_data_ok, iresp_data, out_ready,
        input  pcplus4, ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_misalign
    );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: PC register, single outstanding request,
// one-entry instruction buffer towards decode, redirect-safe cancellation.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            ireq_valid_q;
    logic [XLEN-1:0] ireq_addr_q;
    logic            out_valid_q;
    logic [ILEN-1:0] out_instr_q;
    logic            out_misalign_q;
    logic [XLEN-1:0] discard_pc_c;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    // PC that will be fetched when a discarded response completes (latest redirect wins)
    always_comb begin
        discard_pc_c = pc_q;
        if (bus.redirect) begin
            discard_pc_c = bus.pc_nxt;
        end
    end

    // Fetch FSM; ireq_addr_q doubles as the stale address while discarding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            ireq_valid_q   <= 1'b0;
            ireq_addr_q    <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_misalign_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ireq_valid_q) begin
                        if (bus.iresp_data_ok && bus.redirect) begin
                            pc_q         <= bus.pc_nxt;
                            ireq_valid_q <= is_aligned(bus.pc_nxt);
                            ireq_addr_q  <= bus.pc_nxt;
                        end else if (bus.iresp_data_ok) begin
                            out_instr_q    <= bus.iresp_data;
                            out_valid_q    <= 1'b1;
                            out_misalign_q <= 1'b0;
                            ireq_valid_q   <= 1'b0;
                            state_q        <= HOLD;
                        end else if (bus.redirect) begin
                            pc_q    <= bus.pc_nxt;
                            state_q <= DISCARD;
                        end
                    end else if (bus.redirect) begin
                        pc_q         <= bus.pc_nxt;
                        ireq_valid_q <= is_aligned(bus.pc_nxt);
                        ireq_addr_q  <= bus.pc_nxt;
                    end else if (!is_aligned(pc_q)) begin
                        out_instr_q    <= NOP_INSTR;
                        out_valid_q    <= 1'b1;
                        out_misalign_q <= 1'b1;
                        state_q        <= HOLD;
                    end else begin
                        ireq_valid_q <= 1'b1;
                        ireq_addr_q  <= pc_q;
                    end
                end
                HOLD: begin
                    if (bus.redirect || bus.out_ready) begin
                        pc_q           <= bus.pc_nxt;
                        out_valid_q    <= 1'b0;
                        out_misalign_q <= 1'b0;
                        ireq_valid_q   <= is_aligned(bus.pc_nxt);
                        ireq_addr_q    <= bus.pc_nxt;
                        state_q        <= FETCH;
                    end
                end
                DISCARD: begin
                    pc_q <= discard_pc_c;
                    if (bus.iresp_data_ok) begin
                        ireq_valid_q <= is_aligned(discard_pc_c);
                        ireq_addr_q  <= discard_pc_c;
                        state_q      <= FETCH;
                    end
                end
                default: begin
                    state_q      <= FETCH;
                    ireq_valid_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pcplus4      = pc_q + XLEN'(4);
    assign bus.ireq_valid   = ireq_valid_q;
    assign bus.ireq_addr    = ireq_addr_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_misalign = out_misalign_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(64'h8000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [63:0] pc_nxt;
        logic        dok;
        logic [31:0] data;
        logic        rdy;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [63:0] e_pc;
        logic        chk_instr;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic redir, input logic [63:0] pc_nxt, input logic dok,
                       input logic [31:0] data, input logic rdy, input logic e_iv,
                       input logic [63:0] e_addr, input logic e_ov, input logic [63:0] e_pc,
                       input logic chk_instr, input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.redir = redir; v.pc_nxt = pc_nxt; v.dok = dok; v.data = data; v.rdy = rdy;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        v.chk_instr = chk_instr; v.e_instr = e_instr; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.redirect      = 1'b0;
        bus.pc_nxt        = 64'h0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = 32'h0;
        bus.out_ready     = 1'b0;
    endtask

    localparam logic [63:0] RPC = 64'h8000_0000;
    localparam logic [63:0] ZZ  = 64'h0;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        drive_idle();

        // redir pc_nxt dok data rdy | e_iv e_addr e_ov e_pc chk e_instr e_mis
        // Basic fetch: request issued, response after 3 idle cycles
        add(0, ZZ, 0, 0, 0,  1, RPC, 0, RPC, 1, 32'h0, 0);
        add(0, ZZ, 0, 0, 0,  1, RPC, 0, RPC, 0, 32'h0, 0);
        add(0, ZZ, 0, 0, 0,  1, RPC, 0, RPC, 0, 32'h0, 0);
        add(0, ZZ, 0, 0, 0,  1, RPC, 0, RPC, 0, 32'h0, 0);
        add(0, ZZ, 1, 32'h0010_0093, 0,  0, ZZ, 1, RPC, 1, 32'h0010_0093, 0);
        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++)
            add(0, 64'h1234, 0, 32'hdead_beef, 0,  0, ZZ, 1, RPC, 1, 32'h0010_0093, 0);
        add(0, 64'h8000_0004, 0, 0, 1,  1, 64'h8000_0004, 0, 64'h8000_0004, 0, 32'h0, 0);
        add(0, ZZ, 1, 32'h0020_0113, 0,  0, ZZ, 1, 64'h8000_0004, 1, 32'h0020_0113, 0);
        add(0, 64'h8000_0008, 0, 0, 1,  1, 64'h8000_0008, 0, 64'h8000_0008, 0, 32'h0, 0);
        // Redirect while request in flight -> discard stale response
        add(0, ZZ, 0, 0, 0,  1, 64'h8000_0008, 0, 64'h8000_0008, 0, 32'h0, 0);
        add(1, 64'h8000_1000, 0, 0, 0,  1, 64'h8000_0008, 0, 64'h8000_1000, 0, 32'h0, 0);
        add(0, ZZ, 0, 0, 0,  1, 64'h8000_0008, 0, 64'h8000_1000, 0, 32'h0, 0);
        add(0, ZZ, 1, 32'hbad0_0001, 0,  1, 64'h8000_1000, 0, 64'h8000_1000, 1, 32'h0020_0113, 0);
        // Redirect coincident with data_ok drops the data
        add(1, 64'h8000_2000, 1, 32'hbad0_0002, 0,  1, 64'h8000_2000, 0, 64'h8000_2000, 1, 32'h0020_0113, 0);
        add(0, ZZ, 0, 0, 0,  1, 64'h8000_2000, 0, 64'h8000_2000, 0, 32'h0, 0);
        add(0, ZZ, 1, 32'h0030_0193, 0,  0, ZZ, 1, 64'h8000_2000, 1, 32'h0030_0193, 0);
        // Redirect beats out_ready in HOLD; target is misaligned
        add(1, 64'h8000_0002, 0, 0, 1,  0, ZZ, 0, 64'h8000_0002, 0, 32'h0, 0);
        add(0, ZZ, 0, 0, 0,  0, ZZ, 1, 64'h8000_0002, 1, 32'h0000_0013, 1);
        add(0, 64'h8000_3000, 0, 0, 1,  1, 64'h8000_3000, 0, 64'h8000_3000, 0, 32'h0, 0);
        // Two redirects during DISCARD: the latest one is fetched
        add(1, 64'h8000_4000, 0, 0, 0,  1, 64'h8000_3000, 0, 64'h8000_4000, 0, 32'h0, 0);
        add(1, 64'h8000_5000, 0, 0, 0,  1, 64'h8000_3000, 0, 64'h8000_5000, 0, 32'h0, 0);
        add(0, ZZ, 1, 32'hbad0_0003, 0,  1, 64'h8000_5000, 0, 64'h8000_5000, 0, 32'h0, 0);
        // pcplus4 wraps at the top of the address space
        add(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 0);
        // Redirect to misaligned pc, then redirect away during the misaligned cycle
        add(1, 64'h8000_0006, 1, 0, 0,  0, ZZ, 0, 64'h8000_0006, 0, 32'h0, 0);
        add(1, 64'h8000_6000, 0, 0, 0,  1, 64'h8000_6000, 0, 64'h8000_6000, 0, 32'h0, 0);
        // Enter DISCARD for the reset test
        add(1, 64'h8000_7000, 0, 0, 0,  1, 64'h8000_6000, 0, 64'h8000_7000, 0, 32'h0, 0);

        // Reset state
        tick();
        chk("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_out_misalign", 64'(bus.out_misalign), 64'd0);
        chk("rst_out_pc", bus.out_pc, RPC);
        chk("rst_pcplus4", bus.pcplus4, RPC + 64'd4);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.redirect      = vecs[i].redir;
            bus.pc_nxt        = vecs[i].pc_nxt;
            bus.iresp_data_ok = vecs[i].dok;
            bus.iresp_data    = vecs[i].data;
            bus.out_ready     = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_ireq_valid", i), 64'(bus.ireq_valid), 64'(vecs[i].e_iv));
            if (vecs[i].e_iv) chk($sformatf("v%0d_ireq_addr", i), bus.ireq_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_pcplus4", i), bus.pcplus4, vecs[i].e_pc + 64'd4);
            if (vecs[i].chk_instr) chk($sformatf("v%0d_out_instr", i), 64'(bus.out_instr), 64'(vecs[i].e_instr));
            chk($sformatf("v%0d_out_misalign", i), 64'(bus.out_misalign), 64'(vecs[i].e_mis));
        end
        drive_idle();

        // Async reset mid-DISCARD: outputs clear before the next clock edge
        reset = 1'b1;
        #1;
        chk("async_rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        chk("async_rst_out_pc", bus.out_pc, RPC);
        tick();
        bus.iresp_data_ok = 1'b1;
        tick();
        chk("held_rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        chk("held_rst_out_valid", 64'(bus.out_valid), 64'd0);
        bus.iresp_data_ok = 1'b0;
        reset = 1'b0;

        // After release the reset PC is requested within a bounded number of cycles
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                tick();
                if (bus.ireq_valid) seen = 1'b1;
            end
            chk("post_rst_ireq_seen", 64'(seen), 64'd1);
            chk("post_rst_ireq_addr", bus.ireq_addr, RPC);
            chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        end

        // Response to the new request then completes normally
        tick();
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h0040_0213;
        tick();
        bus.iresp_data_ok = 1'b0;
        chk("post_rst_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_hold_instr", 64'(bus.out_instr), 64'h0040_0213);
        chk("post_rst_hold_pc", bus.out_pc, RPC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
